// File: rtl/fsm_pwd_input1_if.sv
// Switch input and code/display outputs of the password-entry front panel.
interface fsm_pwd_input1_if;
  logic [3:0]  sw_in;
  logic [11:0] data_f;
  logic        clock3;
  logic [6:0]  h0;
  logic [6:0]  h1;
  logic [1:0]  count;

  modport master (output sw_in, input data_f, clock3, h0, h1, count);
  modport slave  (input sw_in, output data_f, clock3, h0, h1, count);
endinterface

// File: rtl/fsm_pwd_input1.sv
// Password-entry FSM: captures three hex digits on key edges into a 12-bit code,
// strobes clock3 while the code is complete and drives two active-low 7-seg digits.
module fsm_pwd_input1 (
  input  logic               key,
  input  logic               reset_n,
  fsm_pwd_input1_if.slave    bus
);

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } state_t;

  state_t      state, state_nx;
  logic [11:0] data_q, data_nx;
  logic        clock3_q, clock3_nx;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  always_ff @(posedge key or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S0;
      data_q   <= '0;
      clock3_q <= 1'b0;
    end else begin
      state    <= state_nx;
      data_q   <= data_nx;
      clock3_q <= clock3_nx;
    end
  end

  always_comb begin
    state_nx = state;
    data_nx  = data_q;
    case (state)
      S0: begin
        data_nx[11:8] = bus.sw_in;
        state_nx      = S1;
      end
      S1: begin
        data_nx[7:4] = bus.sw_in;
        state_nx     = S2;
      end
      S2: begin
        data_nx[3:0] = bus.sw_in;
        state_nx     = S3;
      end
      S3: begin
        // A completed code is dropped wholesale; S0 is reachable only via reset.
        data_nx  = {bus.sw_in, 8'h00};
        state_nx = S1;
      end
    endcase
    clock3_nx = (state_nx == S3);
  end

  assign bus.data_f = data_q;
  assign bus.clock3 = clock3_q;
  assign bus.count  = state;
  assign bus.h0     = seg7(bus.sw_in);
  assign bus.h1     = seg7({2'b00, state});

endmodule

// File: tb/tb_fsm_pwd_input1.sv
// Directed bench for fsm_pwd_input1 with a digit-queue reference model.
module tb_fsm_pwd_input1;

  logic key;
  logic reset_n;
  logic key_run;
  int   tests;
  int   fails;

  fsm_pwd_input1_if bus ();

  fsm_pwd_input1 dut (
    .key     (key),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Key toggles only while key_run is set; otherwise it parks low.
  initial key = 1'b0;
  always begin
    #5;
    key = key_run ? ~key : 1'b0;
  end

  logic [6:0] seg_tab [16];
  initial begin
    seg_tab[0]  = 7'b1000000; seg_tab[1]  = 7'b1111001;
    seg_tab[2]  = 7'b0100100; seg_tab[3]  = 7'b0110000;
    seg_tab[4]  = 7'b0011001; seg_tab[5]  = 7'b0010010;
    seg_tab[6]  = 7'b0000010; seg_tab[7]  = 7'b1111000;
    seg_tab[8]  = 7'b0000000; seg_tab[9]  = 7'b0010000;
    seg_tab[10] = 7'b0001000; seg_tab[11] = 7'b0000011;
    seg_tab[12] = 7'b1000110; seg_tab[13] = 7'b0100001;
    seg_tab[14] = 7'b0000110; seg_tab[15] = 7'b0001110;
  end

  // Reference model: the digits of the current code, oldest first.
  logic [3:0] digs[$];
  always @(posedge key or negedge reset_n) begin
    if (!reset_n) digs.delete();
    else begin
      if (digs.size() == 3) digs.delete();
      digs.push_back(bus.sw_in);
    end
  end

  function automatic logic [11:0] model_code();
    logic [11:0] c;
    c = '0;
    for (int i = 0; i < digs.size(); i++)
      c = c | (12'(digs[i]) << (8 - 4 * i));
    return c;
  endfunction

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous comparison against the model, away from the key rising edge.
  always @(negedge key) begin
    chk("mdl_count",  12'(bus.count),  12'(digs.size()));
    chk("mdl_data",   bus.data_f,      model_code());
    chk("mdl_clock3", 12'(bus.clock3), 12'(digs.size() == 3));
    chk("mdl_h0",     12'(bus.h0),     12'(seg_tab[bus.sw_in]));
    chk("mdl_h1",     12'(bus.h1),     12'(seg_tab[digs.size()]));
  end

  task automatic key_step(input logic [3:0] v);
    bus.sw_in = v;
    @(posedge key);
    #1;
  endtask

  task automatic outs(input string tag, input logic [11:0] d, input logic [1:0] c, input logic k3);
    chk({tag, "_data"},   bus.data_f,      d);
    chk({tag, "_count"},  12'(bus.count),  12'(c));
    chk({tag, "_clock3"}, 12'(bus.clock3), 12'(k3));
  endtask

  logic [1:0]  exp_cnt [9];
  logic [11:0] exp_dat [9];

  initial begin
    tests   = 0;
    fails   = 0;
    key_run = 1'b0;
    reset_n = 1'b0;
    bus.sw_in = 4'h7;
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd3};
    exp_dat = '{12'h000, 12'h010, 12'h012, 12'h300, 12'h340, 12'h345,
                12'h600, 12'h670, 12'h678};
    #3;
    outs("rst", 12'h000, 2'd0, 1'b0);
    chk("rst_h1", 12'(bus.h1), 12'(7'b1000000));
    chk("rst_h0", 12'(bus.h0), 12'(7'b1111000));
    reset_n = 1'b1;
    key_run = 1'b1;

    key_step(4'h1); outs("e1", 12'h100, 2'd1, 1'b0);
    key_step(4'h2); outs("e2", 12'h120, 2'd2, 1'b0);
    key_step(4'h3); outs("e3", 12'h123, 2'd3, 1'b1);
    chk("e3_h1", 12'(bus.h1), 12'(7'b0110000));
    key_step(4'hA); outs("wrap", 12'hA00, 2'd1, 1'b0);

    reset_n = 1'b0; #1; reset_n = 1'b1;
    for (int unsigned i = 0; i < 9; i++) begin
      key_step(4'(i));
      outs($sformatf("run%0d", i), exp_dat[i], exp_cnt[i], exp_cnt[i] == 2'd3);
    end

    reset_n = 1'b0; #1; reset_n = 1'b1;
    key_step(4'h4);
    key_step(4'h5); outs("pre", 12'h450, 2'd2, 1'b0);
    reset_n = 1'b0;
    #1;
    outs("midrst", 12'h000, 2'd0, 1'b0);
    chk("midrst_h1", 12'(bus.h1), 12'(7'b1000000));
    reset_n = 1'b1;
    key_step(4'h9); outs("post", 12'h900, 2'd1, 1'b0);

    key_run = 1'b0;
    #20;
    for (int unsigned v = 0; v < 16; v++) begin
      bus.sw_in = 4'(v);
      #1;
      chk($sformatf("sweep_h0_%0d", v), 12'(bus.h0), 12'(seg_tab[v]));
      outs($sformatf("sweep%0d", v), 12'h900, 2'd1, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
